// File: rtl/poly_synth_pkg.sv
// poly_synth_pkg: waveform modes, note phase increments and noise LFSR constants
// shared by poly_synth_core and poly_osc_voice.
package poly_synth_pkg;
  typedef enum logic [1:0] {SQUARE, SAW, TRI, NOISE} wave_mode_t;
  // Increments for a 24-bit accumulator at 10 MHz, key 0 = C4; keys 13..15 are unused
  localparam logic [15:0][23:0] NOTE_INC = {
    24'd0,   24'd0,   24'd0,   24'd878, 24'd829, 24'd782, 24'd738, 24'd697,
    24'd658, 24'd621, 24'd586, 24'd553, 24'd522, 24'd493, 24'd465, 24'd439};
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/poly_osc_voice.sv
// poly_osc_voice: one phase-accumulator oscillator with waveform shaping.
// With POLY_SYNTH_NOISE_EN it also plays the shared noise sample and flags MSB falls.
module poly_osc_voice
  import poly_synth_pkg::*;
#(
  parameter int PHASE_W  = 24,
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                en,
  input  logic                active_i,
  input  logic [3:0]          key_i,
  input  logic [1:0]          mode_i,
`ifdef POLY_SYNTH_NOISE_EN
  input  logic [SAMPLE_W-1:0] noise_i,
  output logic                msb_fall_o,
`endif
  output logic [SAMPLE_W-1:0] sample_o
);
  logic [PHASE_W-1:0] phase_q, phase_d, phase;
  logic [3:0] key_q, key_d;
  logic act_q, act_d;
  logic [SAMPLE_W-1:0] top, noise;
`ifdef POLY_SYNTH_NOISE_EN
  assign noise = noise_i;
  assign msb_fall_o = active_i & en & phase[PHASE_W-1] & ~phase_d[PHASE_W-1];
`else
  assign noise = '0;
`endif
  always_comb begin
    key_d = key_i;
    act_d = active_i;
    // A newly taken or changed key starts from phase 0 on this very cycle
    phase = (!act_q || key_q != key_i) ? '0 : phase_q;
    phase_d = (active_i && en) ? phase + PHASE_W'(NOTE_INC[key_i]) : '0;
    top = phase[PHASE_W-1 -: SAMPLE_W];
    sample_o = !active_i        ? '0 :
               mode_i == SQUARE ? (phase[PHASE_W-1] ? '0 : '1) :
               mode_i == SAW    ? top :
               mode_i == TRI    ? {top[SAMPLE_W-2:0], 1'b0} ^ {SAMPLE_W{top[SAMPLE_W-1]}} :
                                  noise;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      phase_q <= '0;
      key_q   <= '0;
      act_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      key_q   <= key_d;
      act_q   <= act_d;
    end
endmodule

// File: rtl/poly_synth_core.sv
// poly_synth_core: polyphonic keypad synth with voice allocation, averaging mixer and PWM DAC.
// Define POLY_SYNTH_NOISE_EN to add the NOISE waveform mode driven by a 16-bit Galois LFSR.
module poly_synth_core
  import poly_synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NUM_KEYS   = 13,
  parameter int PHASE_W    = 24,
  parameter int SAMPLE_W   = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  en,
  input  logic [NUM_KEYS-1:0]   keypad_i,
  input  logic                  mode_i,
  output logic                  pwm_o,
  output logic [1:0]            mode_o,
  output logic [NUM_VOICES-1:0] voice_active_o
);
  localparam int LOG_V = $clog2(NUM_VOICES);
  localparam int MIX_W = SAMPLE_W + LOG_V;
  logic [NUM_KEYS-1:0] keys_q, keys_d, rem;
  logic btn_q, btn_d, btn_prev_q, btn_prev_d;
  wave_mode_t mode_q, mode_d;
  logic [NUM_VOICES-1:0] active;
  logic [NUM_VOICES-1:0][3:0] voice_key;
  logic [NUM_VOICES-1:0][SAMPLE_W-1:0] sample;
  logic [MIX_W-1:0] sum_q, sum_d;
  logic [SAMPLE_W-1:0] mix, cnt_q, cnt_d, duty_q, duty_d;
  logic pwm_q, pwm_d;
`ifdef POLY_SYNTH_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [NUM_VOICES-1:0] fall;
  always_comb lfsr_d = |fall ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0)) : lfsr_q;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) lfsr_q <= LFSR_SEED;
    else lfsr_q <= lfsr_d;
`endif
  // Voice v takes the lowest remaining pressed key; extra keys fall off the end
  always_comb begin
    active = '0;
    voice_key = '0;
    rem = keys_q;
    for (int v = 0; v < NUM_VOICES; v++) begin
      for (int k = NUM_KEYS - 1; k >= 0; k--)
        if (rem[k]) voice_key[v] = 4'(k);
      active[v] = |rem;
      rem = rem & (rem - NUM_KEYS'(1));
    end
  end
  always_comb begin
    keys_d = keypad_i;
    btn_d = mode_i;
    btn_prev_d = btn_q;
`ifdef POLY_SYNTH_NOISE_EN
    mode_d = (btn_q && !btn_prev_q) ? wave_mode_t'(mode_q + 2'd1) : mode_q;
`else
    mode_d = (btn_q && !btn_prev_q) ? (mode_q == TRI ? SQUARE : wave_mode_t'(mode_q + 2'd1)) : mode_q;
`endif
    sum_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) sum_d = sum_d + MIX_W'(sample[v]);
    mix = SAMPLE_W'(sum_q >> LOG_V);
    cnt_d = en ? cnt_q + SAMPLE_W'(1) : '0;
    duty_d = !en ? '0 : (cnt_q == '0 ? mix : duty_q);
    pwm_d = en && (cnt_q < duty_d);
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      keys_q     <= '0;
      btn_q      <= 1'b0;
      btn_prev_q <= 1'b0;
      mode_q     <= SQUARE;
      sum_q      <= '0;
      cnt_q      <= '0;
      duty_q     <= '0;
      pwm_q      <= 1'b0;
    end else begin
      keys_q     <= keys_d;
      btn_q      <= btn_d;
      btn_prev_q <= btn_prev_d;
      mode_q     <= mode_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
    end
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    poly_osc_voice #(.PHASE_W(PHASE_W), .SAMPLE_W(SAMPLE_W)) u_voice (
      .clk      (clk),
      .n_rst    (n_rst),
      .en       (en),
      .active_i (active[v]),
      .key_i    (voice_key[v]),
      .mode_i   (mode_q),
`ifdef POLY_SYNTH_NOISE_EN
      .noise_i  (lfsr_q[15 -: SAMPLE_W]),
      .msb_fall_o(fall[v]),
`endif
      .sample_o (sample[v])
    );
  end
  assign pwm_o = pwm_q;
  assign mode_o = mode_q;
  assign voice_active_o = active;
endmodule

// File: tb/tb_poly_synth_core.sv
// tb_poly_synth_core: directed table-driven bench for poly_synth_core, duty measured
// as pwm_o high cycles over 256-cycle windows.
module tb_poly_synth_core;
  localparam int NK = 13, NV = 4;
  logic clk = 1'b0, n_rst = 1'b0, en = 1'b1, mode_i = 1'b0, pwm_o;
  logic [NK-1:0] keypad_i = '0;
  logic [1:0] mode_o;
  logic [NV-1:0] voice_active_o;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {
    logic [NK-1:0] keys;
    logic [NV-1:0] act;
    logic [15:0]   vkeys;
    int            hi;
  } vec_t;
  vec_t tbl [8];
  int exp_modes [3];
  int exp_held, p, hi;

  poly_synth_core #(.NUM_VOICES(NV), .NUM_KEYS(NK), .PHASE_W(24), .SAMPLE_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .en(en), .keypad_i(keypad_i), .mode_i(mode_i),
    .pwm_o(pwm_o), .mode_o(mode_o), .voice_active_o(voice_active_o));

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #20000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  task automatic chk_near(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask
  task automatic chk(input string name, input int act, input int exp);
    chk_near(name, act, exp, 0);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic window(output int h);
    h = 0;
    repeat (256) begin
      @(negedge clk);
      h += int'(pwm_o);
    end
  endtask
  task automatic pulse_mode();
    mode_i = 1'b1;
    step(2);
    mode_i = 1'b0;
    step(3);
  endtask
  task automatic set_mode(input int target);
    for (int i = 0; i < 4 && int'(mode_o) != target; i++) pulse_mode();
    chk("set_mode", mode_o, target);
  endtask
  // Single-voice duty from an ideal phase = inc*t (sum of one voice >> 2)
  function automatic int exp_duty(input int mode, input int inc, input int t);
    int ph, top, s;
    ph = (inc * t) % (1 << 24);
    top = ph >> 16;
    s = mode == 0 ? (top < 128 ? 255 : 0) :
        mode == 1 ? top :
                    (top < 128 ? 2 * top : 511 - 2 * top);
    return s >> 2;
  endfunction
  task automatic measure(input string name, input int mode, input int inc,
                         input int start, input int t, input int tol);
    int h;
    wait_to(start + t - 128);
    window(h);
    chk_near(name, h, exp_duty(mode, inc, t), tol);
  endtask

  initial begin
    tbl[0] = '{13'h0001, 4'b0001, 16'h0000, 63};
    tbl[1] = '{13'h0005, 4'b0011, 16'h0020, 127};
    tbl[2] = '{13'h1095, 4'b1111, 16'h7420, 255};
    tbl[3] = '{13'h1091, 4'b1111, 16'hC740, 255};
    tbl[4] = '{13'h1000, 4'b0001, 16'h000C, 63};
    tbl[5] = '{13'h0000, 4'b0000, 16'h0000, 0};
    tbl[6] = '{13'h1FFF, 4'b1111, 16'h3210, 255};
    tbl[7] = '{13'h0828, 4'b0111, 16'h0B53, 191};
`ifdef POLY_SYNTH_NOISE_EN
    exp_modes = '{1, 2, 3};
    exp_held = 0;
`else
    exp_modes = '{1, 2, 0};
    exp_held = 1;
`endif
    step(2);
    chk("rst_pwm", pwm_o, 0);
    chk("rst_mode", mode_o, 0);
    chk("rst_active", voice_active_o, 0);
    n_rst = 1'b1;
    step(2);
    chk("post_rst_pwm", pwm_o, 0);
    chk("post_rst_mode", mode_o, 0);
    chk("post_rst_active", voice_active_o, 0);

    for (int i = 0; i < 8; i++) begin
      keypad_i = tbl[i].keys;
      step(800);
      chk($sformatf("alloc_active[%0d]", i), voice_active_o, tbl[i].act);
      chk($sformatf("alloc_keys[%0d]", i), int'(dut.voice_key), tbl[i].vkeys);
      window(hi);
      chk($sformatf("alloc_duty[%0d]", i), hi, tbl[i].hi);
    end

    keypad_i = '0;
    step(4);
    keypad_i = 13'h0001;
    p = cyc;
    measure("sq_first_half", 0, 439, p, 10000, 0);
    measure("sq_second_half", 0, 439, p, 25000, 0);
    measure("sq_after_wrap", 0, 439, p, 40000, 0);

    keypad_i = '0;
    for (int i = 0; i < 3; i++) begin
      pulse_mode();
      chk($sformatf("mode_pulse[%0d]", i), mode_o, exp_modes[i]);
    end
    mode_i = 1'b1;
    step(100);
    chk("mode_held", mode_o, exp_held);
    mode_i = 1'b0;
    step(3);
    chk("mode_held_release", mode_o, exp_held);

    set_mode(1);
    keypad_i = 13'h0200;
    p = cyc;
    measure("saw_quarter", 1, 738, p, 5683, 3);
    measure("saw_half", 1, 738, p, 11366, 3);
    measure("saw_late", 1, 738, p, 20000, 3);
    keypad_i = 13'h0100;
    p = cyc;
    measure("saw_key_change_clear", 1, 697, p, 600, 3);

    set_mode(2);
    keypad_i = 13'h1000;
    p = cyc;
    measure("tri_quarter", 2, 878, p, 4777, 3);
    measure("tri_peak", 2, 878, p, 9554, 3);
    wait_to(p + 9800);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("en_off_pwm", pwm_o, 0);
    chk("en_off_active", voice_active_o, 4'b0001);
    window(hi);
    chk("en_off_window", hi, 0);
    @(posedge clk);
    #1;
    en = 1'b1;
    p = cyc;
    measure("en_restart_phase", 2, 878, p, 600, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
